// File: rtl/digit_scan_sequencer_pkg.sv
// Shared types and helpers for the digit scan sequencer.
// Holds the FSM state type, the decoder enable encodings and the timer width helper.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    // {G1, G2A_bar, G2B_bar}
    localparam logic [2:0] DEC_EN_ON  = 3'b100;
    localparam logic [2:0] DEC_EN_OFF = 3'b011;

    function automatic int timer_width(
        input int prescale,
        input int blank
    );
        int m;
        m = (prescale > blank) ? prescale : blank;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter that stops at zero.
// Ports: clk, rst (sync, active-high), load, load_value[W-1:0], zero.
module scan_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/digit_scan_sequencer.sv
// Scan driver for a 3-to-8 decoder: steps {C,B,A} with blanking between digits.
// Ports: clk, rst (sync, active-high), run, A/B/C select, G1/G2A_bar/G2B_bar
// enables, frame_done pulse, busy. Macro SCAN_SKIP_EN adds input skip_mask[7:0].
module digit_scan_sequencer #(
    parameter int PRESCALE   = 4,
    parameter int BLANK      = 1,
    parameter int NUM_DIGITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
`ifdef SCAN_SKIP_EN
    input  logic [7:0] skip_mask,
`endif
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       G1,
    output logic       G2A_bar,
    output logic       G2B_bar,
    output logic       frame_done,
    output logic       busy
);

    import scan_pkg::*;

    localparam int TIMER_W = timer_width(PRESCALE, BLANK);

    localparam logic [TIMER_W-1:0] PRE_LD =
        TIMER_W'(PRESCALE - 1);
    localparam logic [TIMER_W-1:0] BLK_LD =
        TIMER_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [2:0] LAST_SEL = 3'(NUM_DIGITS - 1);

    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("PRESCALE must be 1..65535");
    end
    if (BLANK < 0 || BLANK > 65535) begin : g_bad_blank
        $error("BLANK must be 0..65535");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("NUM_DIGITS must be 1..8");
    end

    scan_state_t state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic [2:0]  en_q, en_d;
    logic        fd_q, fd_d;
    logic        busy_q;
    logic        load;
    logic [TIMER_W-1:0] load_value;
    logic        t_zero;
    logic        skip_d;

    scan_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_value(load_value),
        .zero      (t_zero)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        load       = 1'b0;
        load_value = '0;
        fd_d       = 1'b0;
        unique case (1'b1)
            (state_q == scan_pkg::IDLE): begin
                sel_d = '0;
                if (run) begin
                    load = 1'b1;
                    if (BLANK == 0) begin
                        state_d    = scan_pkg::DRIVE;
                        load_value = PRE_LD;
                    end else begin
                        state_d    = scan_pkg::BLANK;
                        load_value = BLK_LD;
                    end
                end
            end
            (state_q == scan_pkg::BLANK): begin
                if (!run) begin
                    state_d = scan_pkg::IDLE;
                    sel_d   = '0;
                    load    = 1'b1;
                end else if (t_zero) begin
                    state_d    = scan_pkg::DRIVE;
                    load       = 1'b1;
                    load_value = PRE_LD;
                end
            end
            (state_q == scan_pkg::DRIVE): begin
                // Slot always runs to completion; run only
                // decides where we go once it ends.
                if (t_zero) begin
                    load  = 1'b1;
                    fd_d  = (sel_q == LAST_SEL);
                    sel_d = (sel_q == LAST_SEL) ?
                            3'd0 : sel_q + 3'd1;
                    if (!run) begin
                        state_d = scan_pkg::IDLE;
                        sel_d   = '0;
                    end else if (BLANK == 0) begin
                        load_value = PRE_LD;
                    end else begin
                        state_d    = scan_pkg::BLANK;
                        load_value = BLK_LD;
                    end
                end
            end
            default: begin
                state_d = scan_pkg::IDLE;
                sel_d   = '0;
            end
        endcase
    end

`ifdef SCAN_SKIP_EN
    logic skip_q;
    logic drive_entry;

    // The mask bit is captured once per slot so a mid-slot
    // mask change cannot chop a digit's drive window.
    always_comb begin
        drive_entry = (state_d == scan_pkg::DRIVE) &&
                      ((state_q != scan_pkg::DRIVE) || t_zero);
        skip_d = drive_entry ? skip_mask[sel_d] : skip_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skip_q <= 1'b0;
        end else begin
            skip_q <= skip_d;
        end
    end
`else
    assign skip_d = 1'b0;
`endif

    assign en_d = ((state_d == scan_pkg::DRIVE) && !skip_d) ?
                  DEC_EN_ON : DEC_EN_OFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= scan_pkg::IDLE;
            sel_q   <= '0;
            en_q    <= DEC_EN_OFF;
            fd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            fd_q    <= fd_d;
            busy_q  <= (state_d != scan_pkg::IDLE);
        end
    end

    assign {C, B, A}              = sel_q;
    assign {G1, G2A_bar, G2B_bar} = en_q;
    assign frame_done             = fd_q;
    assign busy                   = busy_q;

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// Scoreboard bench for digit_scan_sequencer over several parameter sets.
// Honours SCAN_SKIP_EN (drives skip_mask on instance 0 when defined).
module tb_digit_scan_sequencer;

    localparam int NI = 6;

`ifdef SCAN_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    function automatic int cfg_p(input int g);
        case (g)
            0: return 4;
            1: return 2;
            2: return 4;
            3: return 3;
            4: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int cfg_b(input int g);
        case (g)
            0: return 1;
            1: return 0;
            2: return 1;
            3: return 2;
            4: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_n(input int g);
        case (g)
            0: return 3;
            1: return 8;
            2: return 8;
            3: return 5;
            4: return 2;
            default: return 1;
        endcase
    endfunction

    logic clk;
    logic rst_v  [NI];
    logic run_v  [NI];
    logic a_w    [NI];
    logic b_w    [NI];
    logic c_w    [NI];
    logic g1_w   [NI];
    logic g2a_w  [NI];
    logic g2b_w  [NI];
    logic fd_w   [NI];
    logic busy_w [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        digit_scan_sequencer #(
            .PRESCALE  (cfg_p(g)),
            .BLANK     (cfg_b(g)),
            .NUM_DIGITS(cfg_n(g))
        ) u_dut (
            .clk       (clk),
            .rst       (rst_v[g]),
            .run       (run_v[g]),
`ifdef SCAN_SKIP_EN
            .skip_mask ((g == 0) ? 8'b0000_0010 : 8'h00),
`endif
            .A         (a_w[g]),
            .B         (b_w[g]),
            .C         (c_w[g]),
            .G1        (g1_w[g]),
            .G2A_bar   (g2a_w[g]),
            .G2B_bar   (g2b_w[g]),
            .frame_done(fd_w[g]),
            .busy      (busy_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        logic [7:0] exp;
        string      tag;
        int         k;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;

    // {busy, frame_done, G1, G2A_bar, G2B_bar, C, B, A}
    function automatic logic [7:0] word(input int g);
        return {busy_w[g], fd_w[g], g1_w[g], g2a_w[g],
                g2b_w[g], c_w[g], b_w[g], a_w[g]};
    endfunction

    function automatic logic [7:0] mk(
        input bit busy, input bit fd,
        input bit en,   input int sel
    );
        logic [2:0] e3;
        e3 = en ? 3'b100 : 3'b011;
        return {busy, fd, e3, 3'(sel)};
    endfunction

    // Expected word k cycles after run is first seen in IDLE.
    function automatic logic [7:0] pat(
        input int k, input int p, input int b,
        input int n, input bit skip1
    );
        int len, pos, slot;
        bit en, fd;
        len  = p + b;
        pos  = k % len;
        slot = (k / len) % n;
        en   = (pos >= b) && !(skip1 && slot == 1);
        fd   = (k > 0) && (k % (len * n) == 0);
        return mk(1'b1, fd, en, slot);
    endfunction

    localparam logic [7:0] IDLE_W = 8'h18;

    task automatic step(
        input int g, input bit r, input bit rn,
        input logic [7:0] e, input string tag, input int k
    );
        item_t it;
        @(negedge clk);
        rst_v[g] = r;
        run_v[g] = rn;
        it.dut = g;
        it.exp = e;
        it.tag = tag;
        it.k   = k;
        sb.push_back(it);
    endtask

    logic [2:0] prev_sel [NI];
    bit         prev_ok  [NI];

    initial begin
        for (int g = 0; g < NI; g++) prev_ok[g] = 1'b0;
        forever begin
            item_t it;
            logic [7:0] got;
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                it  = sb.pop_front();
                got = word(it.dut);
                checks++;
                if (got !== it.exp) begin
                    errors++;
                    $display("FAIL %s dut%0d k=%0d: got %h want %h",
                             it.tag, it.dut, it.k, got, it.exp);
                end
            end
            for (int g = 0; g < NI; g++) begin
                logic [2:0] s;
                s = {c_w[g], b_w[g], a_w[g]};
                if (g != 1 && prev_ok[g]) begin
                    checks++;
                    if (g1_w[g] === 1'b1 && s !== prev_sel[g]) begin
                        errors++;
                        $display("FAIL glitch dut%0d: sel %0d->%0d while enabled",
                                 g, prev_sel[g], s);
                    end
                end
                prev_sel[g] = s;
                prev_ok[g]  = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int g = 0; g < NI; g++) begin
            rst_v[g] = 1'b1;
            run_v[g] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) rst_v[g] = 1'b0;

        // 3 digits, PRESCALE 4, BLANK 1: 15-cycle frame
        step(0, 1'b1, 1'b0, IDLE_W, "reset0", 0);
        for (int k = 0; k < 50; k++)
            step(0, 1'b0, 1'b1, pat(k, 4, 1, 3, SKIP), "scan3", k);
        step(0, 1'b1, 1'b0, IDLE_W, "park0", 0);

        // BLANK 0: enables stay on, wrap 7->0
        step(1, 1'b1, 1'b0, IDLE_W, "reset1", 0);
        for (int k = 0; k < 40; k++)
            step(1, 1'b0, 1'b1, pat(k, 2, 0, 8, 1'b0), "noblank", k);
        step(1, 1'b1, 1'b0, IDLE_W, "park1", 0);

        // run drops on 2nd DRIVE cycle of digit 1
        step(2, 1'b1, 1'b0, IDLE_W, "reset2", 0);
        for (int k = 0; k < 16; k++)
            step(2, 1'b0, (k < 8),
                 (k < 10) ? pat(k, 4, 1, 8, 1'b0) : IDLE_W,
                 "runstop", k);

        // rst mid-DRIVE of digit 5
        for (int k = 0; k <= 28; k++)
            step(2, (k == 28), 1'b1,
                 (k == 28) ? IDLE_W : pat(k, 4, 1, 8, 1'b0),
                 "rstmid", k);

        // rst on the edge that would raise frame_done
        for (int k = 0; k <= 40; k++)
            step(2, (k == 40), 1'b1,
                 (k == 40) ? IDLE_W : pat(k, 4, 1, 8, 1'b0),
                 "rstfd", k);
        step(2, 1'b0, 1'b0, IDLE_W, "idle2", 0);

        // single digit: frame_done every slot
        step(5, 1'b1, 1'b0, IDLE_W, "reset5", 0);
        for (int k = 0; k < 12; k++)
            step(5, 1'b0, 1'b1, pat(k, 2, 1, 1, 1'b0), "onedig", k);
        step(5, 1'b1, 1'b0, IDLE_W, "park5", 0);

        // random run/rst on two more parameter sets
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            for (int g = 3; g < 5; g++) begin
                run_v[g] = ($urandom_range(0, 9) != 0);
                rst_v[g] = ($urandom_range(0, 99) == 0);
            end
        end
        @(negedge clk);
        run_v[3] = 1'b0;
        run_v[4] = 1'b0;

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
